// File: rtl/rtc_pkg.sv
// Shared constants for the RTC read-side blocks: mapped register addresses,
// capture FSM encoding and default sweep timeout.
package rtc_pkg;

  localparam int NUM_MAPPED = 9;

  localparam logic [7:0] ADDR_SEG    = 8'h21;
  localparam logic [7:0] ADDR_MIN    = 8'h22;
  localparam logic [7:0] ADDR_HORA   = 8'h23;
  localparam logic [7:0] ADDR_DIA    = 8'h24;
  localparam logic [7:0] ADDR_MES    = 8'h25;
  localparam logic [7:0] ADDR_ANIO   = 8'h26;
  localparam logic [7:0] ADDR_T_SEG  = 8'h41;
  localparam logic [7:0] ADDR_T_MIN  = 8'h42;
  localparam logic [7:0] ADDR_T_HORA = 8'h43;

  // Slot i of the staging/visible banks holds the register at ADDR_TABLE[i].
  localparam logic [NUM_MAPPED-1:0][7:0] ADDR_TABLE = {
    ADDR_T_HORA, ADDR_T_MIN, ADDR_T_SEG, ADDR_ANIO, ADDR_MES,
    ADDR_DIA, ADDR_HORA, ADDR_MIN, ADDR_SEG
  };

  localparam logic [23:0] TIMEOUT_DEFAULT = 24'd10_000_000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

endpackage

// File: rtl/rtc_addr_decode.sv
// RTC register address to one-hot bank slot decoder, plus a hit flag for
// addresses that map to any slot.
import rtc_pkg::*;

module rtc_addr_decode (
  input  logic [7:0]            i_addr,
  output logic [NUM_MAPPED-1:0] o_onehot,
  output logic                  o_hit
);

  for (genvar g = 0; g < NUM_MAPPED; g++) begin : g_slot
    assign o_onehot[g] = (i_addr == ADDR_TABLE[g]);
  end

  assign o_hit = |o_onehot;

endmodule

// File: rtl/rtc_read_capture.sv
// Captures RTC read bytes into a staging bank and commits full sweeps
// atomically to the visible bank. Optional invalid-BCD scrubbing: RTC_BCD_CHECK_EN.
import rtc_pkg::*;

module rtc_read_capture #(
  parameter logic [23:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter logic [7:0]  LAST_ADDR      = ADDR_T_HORA
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] address,
  input  logic [7:0] data_vga,
  input  logic       Read,
  input  logic       AoD,
  input  logic       IndicadorMaquina,
  input  logic       bit_inicio,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio,
  output logic [7:0] t_seg,
  output logic [7:0] t_min,
  output logic [7:0] t_hora,
  output logic       frame_valid,
  output logic       sweep_error,
  output logic       bcd_error
);

  logic                           r_read_q;
  state_t                         r_state;
  logic [23:0]                    r_cnt;
  logic [NUM_MAPPED-1:0]          r_mask;
  logic [NUM_MAPPED-1:0][7:0]     r_stage;
  logic [NUM_MAPPED-1:0][7:0]     r_vis;
  logic                           r_fv;
  logic                           r_serr;

  logic                           w_cap;
  logic                           w_take;
  logic [NUM_MAPPED-1:0]          w_onehot;
  logic                           w_hit;
  logic [7:0]                     w_byte;

  rtc_addr_decode u_dec (
    .i_addr   (address),
    .o_onehot (w_onehot),
    .o_hit    (w_hit)
  );

  // Read idles high; resetting the delayed copy high avoids a false edge.
  always_ff @(posedge clk or posedge reset)
    if (reset) r_read_q <= 1'b1;
    else       r_read_q <= Read;

  assign w_cap  = ~r_read_q & Read & AoD & IndicadorMaquina;
  assign w_take = w_cap & w_hit & (r_state == COLLECT);

`ifdef RTC_BCD_CHECK_EN
  logic w_bad;
  logic r_bcd_err;

  assign w_bad  = (data_vga[7:4] > 4'd9) | (data_vga[3:0] > 4'd9);
  assign w_byte = w_bad ? 8'h00 : data_vga;

  always_ff @(posedge clk or posedge reset)
    if (reset)               r_bcd_err <= 1'b0;
    else if (w_take && w_bad) r_bcd_err <= 1'b1;

  assign bcd_error = r_bcd_err;
`else
  assign w_byte    = data_vga;
  assign bcd_error = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset)
    if (reset) r_stage <= '0;
    else
      for (int i = 0; i < NUM_MAPPED; i++)
        if (w_take && w_onehot[i]) r_stage[i] <= w_byte;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mask  <= '0;
      r_vis   <= '0;
      r_fv    <= 1'b0;
      r_serr  <= 1'b0;
    end else begin
      r_fv <= 1'b0;
      case (r_state)
        IDLE:
          if (bit_inicio) begin
            r_state <= COLLECT;
            r_mask  <= '0;
            r_cnt   <= '0;
          end
        COLLECT:
          if (!IndicadorMaquina) begin
            r_state <= IDLE;
          end else if (bit_inicio) begin
            // Restart wins, but a byte landing in the same cycle still counts.
            r_cnt  <= '0;
            r_mask <= w_take ? w_onehot : '0;
          end else if (w_take) begin
            r_mask <= r_mask | w_onehot;
            r_cnt  <= '0;
            if (address == LAST_ADDR) r_state <= COMMIT;
          end else if (r_cnt == TIMEOUT_CYCLES - 24'd1) begin
            r_state <= IDLE;
            r_serr  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 24'd1;
          end
        COMMIT: begin
          if (&r_mask) begin
            r_vis  <= r_stage;
            r_fv   <= 1'b1;
            r_serr <= 1'b0;
          end else begin
            r_serr <= 1'b1;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign seg         = r_vis[0];
  assign min         = r_vis[1];
  assign hora        = r_vis[2];
  assign dia         = r_vis[3];
  assign mes         = r_vis[4];
  assign anio        = r_vis[5];
  assign t_seg       = r_vis[6];
  assign t_min       = r_vis[7];
  assign t_hora      = r_vis[8];
  assign frame_valid = r_fv;
  assign sweep_error = r_serr;

endmodule

// File: tb/tb_rtc_read_capture.sv
// Randomized bench for rtc_read_capture against a sweep-level reference model.
module tb_rtc_read_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] address, data_vga;
  logic       Read, AoD, IndicadorMaquina, bit_inicio;
  logic [7:0] seg, min, hora, dia, mes, anio, t_seg, t_min, t_hora;
  logic       frame_valid, sweep_error, bcd_error;

  always #5 clk = ~clk;

  rtc_read_capture #(.TIMEOUT_CYCLES(24'd50)) dut (
    .clk(clk), .reset(reset), .address(address), .data_vga(data_vga),
    .Read(Read), .AoD(AoD), .IndicadorMaquina(IndicadorMaquina),
    .bit_inicio(bit_inicio),
    .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes), .anio(anio),
    .t_seg(t_seg), .t_min(t_min), .t_hora(t_hora),
    .frame_valid(frame_valid), .sweep_error(sweep_error), .bcd_error(bcd_error)
  );

  int n_cmp = 0, n_err = 0;
  int n_fv = 0, m_fv = 0;

  logic [7:0] addrs   [9];
  logic [7:0] m_vis   [9];
  logic [7:0] m_stage [9];
  logic [8:0] m_mask;
  logic       m_serr, m_bcd, m_collect;

  always @(negedge clk) if (frame_valid === 1'b1) n_fv++;

  function automatic logic [7:0] dout(int i);
    case (i)
      0: return seg;    1: return min;   2: return hora;
      3: return dia;    4: return mes;   5: return anio;
      6: return t_seg;  7: return t_min; default: return t_hora;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_bank(string tag);
    for (int i = 0; i < 9; i++) chk($sformatf("%s_b%0d", tag, i), dout(i), m_vis[i]);
    chk({tag, "_serr"}, sweep_error, m_serr);
    chk({tag, "_bcd"}, bcd_error, m_bcd);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 9; i++) begin m_vis[i] = 8'h00; m_stage[i] = 8'h00; end
    m_mask = '0; m_serr = 0; m_bcd = 0; m_collect = 0;
  endtask

  task automatic start();
    @(posedge clk); #1 bit_inicio = 1; IndicadorMaquina = 1;
    @(posedge clk); #1 bit_inicio = 0;
    m_mask = '0; m_collect = 1;
  endtask

  // One read transaction; returns 1 time unit after the capturing edge.
  task automatic rd(logic [7:0] a, logic [7:0] d);
    logic bad;
    @(posedge clk); #1 address = a; data_vga = d; AoD = 1; IndicadorMaquina = 1; Read = 0;
    @(posedge clk); #1 Read = 1;
    @(posedge clk); #1 AoD = 0;
    if (m_collect)
      for (int i = 0; i < 9; i++)
        if (addrs[i] == a) begin
          bad = 0;
`ifdef RTC_BCD_CHECK_EN
          bad = (d[7:4] > 9) || (d[3:0] > 9);
          if (bad) m_bcd = 1;
`endif
          m_stage[i] = bad ? 8'h00 : d;
          m_mask[i]  = 1;
        end
  endtask

  task automatic finish_sweep(string tag);
    logic full;
    full = &m_mask;
    chk({tag, "_fv_early"}, frame_valid, 1'b0);
    @(posedge clk); #1;
    chk({tag, "_fv"}, frame_valid, full);
    if (full) begin
      for (int i = 0; i < 9; i++) m_vis[i] = m_stage[i];
      m_serr = 0; m_fv++;
    end else m_serr = 1;
    m_collect = 0;
    check_bank(tag);
    @(posedge clk); #1;
    chk({tag, "_fv_pulse"}, frame_valid, 1'b0);
  endtask

  task automatic full_sweep(string tag, logic [7:0] v [9]);
    start();
    for (int i = 0; i < 9; i++) rd(addrs[i], v[i]);
    finish_sweep(tag);
  endtask

  initial begin
    logic [7:0] v [9];
    int ord [8];
    int skip, j, t;
    addrs = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    reset = 1; address = 0; data_vga = 0; Read = 1; AoD = 0;
    IndicadorMaquina = 1; bit_inicio = 0;
    model_reset();
    #23;
    check_bank("reset");
    chk("reset_fv", frame_valid, 1'b0);
    reset = 0;

    v = '{8'h45, 8'h59, 8'h23, 8'h31, 8'h12, 8'h17, 8'h05, 8'h10, 8'h01};
    full_sweep("full1", v);

    // Timeout: stall after 22, error must appear exactly 50 cycles later.
    start();
    rd(8'h21, 8'h11); rd(8'h22, 8'h22);
    repeat (45) @(posedge clk); #1;
    chk("tmo_before", sweep_error, 1'b0);
    repeat (5) @(posedge clk); #1;
    m_collect = 0; m_serr = 1;
    chk("tmo_after", sweep_error, 1'b1);
    for (int i = 2; i < 9; i++) rd(addrs[i], 8'h33);
    repeat (2) @(posedge clk); #1;
    check_bank("tmo_idle");

    v = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    full_sweep("full2", v);

    // Missing byte at 24.
    start();
    for (int i = 0; i < 9; i++) if (i != 3) rd(addrs[i], 8'h50 + 8'(i));
    finish_sweep("miss");

    // Write machine: abort sweep, then toggle with data 99.
    start();
    @(posedge clk); #1 IndicadorMaquina = 0; m_collect = 0;
    for (int i = 0; i < 9; i++) begin
      address = addrs[i]; data_vga = 8'h99; AoD = 0; Read = 0;
      @(posedge clk); #1 AoD = 1;
      @(posedge clk); #1 Read = 1;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 9; i++) rd(addrs[i], 8'h99);
    repeat (2) @(posedge clk); #1;
    check_bank("wrmach");

    // Invalid BCD in seg.
    v = '{8'h7A, 8'h00, 8'h12, 8'h01, 8'h02, 8'h24, 8'h30, 8'h00, 8'h00};
    full_sweep("bcd", v);

    // Async reset between 25 and 26.
    start();
    for (int i = 0; i < 5; i++) rd(addrs[i], 8'h42);
    #2 reset = 1;
    #1 model_reset();
    check_bank("midrst");
    #3 reset = 0;
    @(posedge clk); #1;
    chk("midrst_fv", frame_valid, 1'b0);
    v = '{8'h30, 8'h45, 8'h12, 8'h28, 8'h02, 8'h24, 8'h15, 8'h30, 8'h02};
    full_sweep("full3", v);

    for (int r = 0; r < 30; r++) begin
      start();
      for (int k = 0; k < 8; k++) ord[k] = k;
      for (int k = 7; k > 0; k--) begin
        j = $urandom_range(0, k); t = ord[k]; ord[k] = ord[j]; ord[j] = t;
      end
      skip = $urandom_range(0, 35);
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 5) == 0) rd(8'h30, 8'($urandom_range(0, 255)));
        if (k != skip) begin
          rd(addrs[ord[k]], ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255))
                              : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))});
          if ($urandom_range(0, 9) == 0) rd(addrs[ord[k]], 8'($urandom_range(0, 153)));
        end
        if ($urandom_range(0, 15) == 0) start();
      end
      rd(8'h43, 8'($urandom_range(0, 255)));
      finish_sweep($sformatf("rnd%0d", r));
    end

    repeat (2) @(posedge clk); #1;
    chk("fv_count", n_fv, m_fv);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rtc_read_capture.md
Name: rtc_read_capture

Overview:
- Downstream consumer of the RTC protocol block's read path.
- Watches read-phase control (Read, AoD, IndicadorMaquina) and the returned byte data_vga, tags each byte with the current RTC address, and accumulates a full sweep in a staging bank.
- Commits the sweep atomically to a visible shadow bank, so the VGA controller never sees a torn time/date/timer snapshot.

Parameters:
- TIMEOUT_CYCLES, 24'd10_000_000: maximum clk cycles between consecutive captures inside a sweep (100 ms at 100 MHz) before the sweep is aborted.
- LAST_ADDR, 8'h43: address whose capture closes a sweep.

Ports:
- clk  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-high reset
- address  in  8  RTC register address currently being accessed (same bus fed to the protocol block)
- data_vga  in  8  byte returned by the protocol block
- Read  in  1  RTC read strobe, active-low
- AoD  in  1  0 = address phase, 1 = data phase
- IndicadorMaquina  in  1  1 = read machine active, 0 = write machine
- bit_inicio  in  1  sweep-start marker from the protocol block (address 8'h21 in read mode)
- seg, min, hora, dia, mes, anio, t_seg, t_min, t_hora  out  8 each  committed BCD values
- frame_valid  out  1  one-cycle pulse on commit
- sweep_error  out  1  sticky; set on timeout abort, cleared by the next successful commit
- bcd_error  out  1  sticky invalid-BCD flag (feature-dependent, see below)

Behaviour:
- Reset (async, immediate): every output byte = 8'h00; frame_valid, sweep_error and bcd_error = 0; FSM = IDLE; staging bank cleared; capture mask cleared; timeout counter = 0.
- Capture strobe cap_stb:
  - Read_q is Read registered one cycle.
  - cap_stb = (Read_q==0 && Read==1 && AoD==1 && IndicadorMaquina==1), i.e. the rising edge of Read during a data phase of a read.
  - In the cap_stb cycle, data_vga is sampled unchanged (it holds the last value driven while Read was low).
- Address map:
  - 21→seg, 22→min, 23→hora, 24→dia, 25→mes, 26→anio, 41→t_seg, 42→t_min, 43→t_hora.
  - Any other address: byte ignored; no mask bit is set.
- FSM states IDLE, COLLECT, COMMIT:
  - IDLE:
    - bit_inicio==1 → COLLECT; clear mask and timeout counter.
    - cap_stb is ignored in IDLE.
  - COLLECT:
    - cap_stb on a mapped address → write staging[addr], set mask bit, reset timeout counter.
    - cap_stb at LAST_ADDR → write it, then go to COMMIT next cycle.
    - Counter reaches TIMEOUT_CYCLES-1 → IDLE, set sweep_error; visible bank unchanged.
    - IndicadorMaquina falls to 0 → abort to IDLE without flagging.
    - bit_inicio re-asserted → restart: clear mask and counter, stay in COLLECT.
  - COMMIT (one cycle):
    - If all 9 mask bits are set: copy staging→visible, pulse frame_valid, clear sweep_error.
    - Otherwise: set sweep_error and do not copy.
    - Always → IDLE.
- Latency:
  - Visible outputs and the frame_valid pulse change 2 clk after the cap_stb of address 8'h43.
  - Outputs are constant at all other times.
- Simultaneous events:
  - cap_stb and bit_inicio in the same cycle during COLLECT: restart takes priority; the byte is still written to staging and its mask bit is set after the clear.
  - Same address captured twice in one sweep: last write wins.
- Reset mid-sweep: staging discarded; visible bank returns to zeros.

Optional Feature:
- Macro RTC_BCD_CHECK_EN.
- Defined: on each capture, if either nibble > 9:
  - byte is replaced by 8'h00 in staging;
  - bcd_error is set (sticky until reset);
  - the mask bit is still set.
- Undefined: bytes are stored raw; bcd_error is tied to 0.

Decomposition:
- Shared package rtc_pkg holds:
  - address constants ADDR_SEG..ADDR_T_HORA;
  - state encoding IDLE/COLLECT/COMMIT (2-bit);
  - mapped-address count 9;
  - default TIMEOUT_CYCLES.
- One natural sub-module, rtc_addr_decode: combinational address→one-hot(9) plus hit flag, reused by a future write-side block.

Test Plan:
- Full sweep: bit_inicio, then reads of 21..26 = 8'h45,59,23,31,12,17 and 41..43 = 8'h05,10,01 → frame_valid pulse 2 clk after the 43 strobe; seg=45, hora=23, t_hora=01; sweep_error=0.
- Missing byte: sweep skips 24 → no frame_valid; sweep_error=1; visible bank keeps the previous values.
- Timeout: TIMEOUT_CYCLES=50, stall 50 clk after 22 → FSM IDLE, sweep_error=1; a following full sweep clears it and commits.
- Write machine: IndicadorMaquina=0 with Read/AoD toggling and data 8'h99 → no capture; outputs unchanged.
- BCD check with RTC_BCD_CHECK_EN: seg=8'h7A → seg commits 8'h00, bcd_error=1; without the macro → seg=8'h7A, bcd_error=0.
- Async reset asserted between the 25 and 26 captures → all outputs 0 immediately, no frame_valid; the next full sweep commits normally.
